// File: rtl/wb_trace_serializer.sv
// wb_trace_serializer: dual-issue writeback regfile steering plus in-order commit trace FIFO
// Optional feature macro: WB_TRACE_EN (defined -> trace FIFO, stall_req, ovf; undefined -> trace outputs tied 0)
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m_* / s_*                      master / slave writeback slot (valid, wen, waddr, wdata, pc)
//   rf_we1/rf_waddr1/rf_wdata1     regfile port 1 (master), slave wins same-register writes
//   rf_we2/rf_waddr2/rf_wdata2     regfile port 2 (slave)
//   trace_valid/trace_ready        head-entry handshake
//   trace_pc/wen/wnum/wdata        head trace entry
//   stall_req                      fewer than two free FIFO slots
//   ovf                            sticky overflow (entry dropped)
//   commit_cnt                     count of committed instructions
module wb_trace_serializer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        m_wen,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    input  logic [31:0] m_pc,
    input  logic        s_valid,
    input  logic        s_wen,
    input  logic [4:0]  s_waddr,
    input  logic [31:0] s_wdata,
    input  logic [31:0] s_pc,
    output logic        rf_we1,
    output logic [4:0]  rf_waddr1,
    output logic [31:0] rf_wdata1,
    output logic        rf_we2,
    output logic [4:0]  rf_waddr2,
    output logic [31:0] rf_wdata2,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [3:0]  trace_wen,
    output logic [4:0]  trace_wnum,
    output logic [31:0] trace_wdata,
    output logic        stall_req,
    output logic        ovf,
    output logic [31:0] commit_cnt
);
    // slave is younger in program order, so it alone writes a shared destination
    assign rf_we2    = s_valid & s_wen & (s_waddr != '0);
    assign rf_we1    = m_valid & m_wen & (m_waddr != '0) & ~(rf_we2 & (m_waddr == s_waddr));
    assign rf_waddr1 = m_waddr;
    assign rf_wdata1 = m_wdata;
    assign rf_waddr2 = s_waddr;
    assign rf_wdata2 = s_wdata;
`ifdef WB_TRACE_EN
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;
    entry_t        mem [DEPTH];
    entry_t        ent_m, ent_s, head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, free;
    logic          enq_m, enq_s, deq;
    logic [1:0]    enq_n;
    // free space ignores the same-cycle dequeue so enqueue never depends on trace_ready
    always_comb begin
        free  = (AW+1)'(DEPTH) - count;
        enq_m = m_valid && (free != '0);
        enq_s = s_valid && (free > (AW+1)'(enq_m));
        enq_n = {1'b0, enq_m} + {1'b0, enq_s};
        deq   = (count != '0) && trace_ready;
        ent_m = '{m_pc, {4{m_wen && (m_waddr != '0)}}, m_waddr, m_wdata};
        ent_s = '{s_pc, {4{s_wen && (s_waddr != '0)}}, s_waddr, s_wdata};
        head  = mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (enq_m) mem[wr_ptr] <= ent_m;
        if (enq_s) mem[enq_m ? wr_ptr + AW'(1) : wr_ptr] <= ent_s;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            commit_cnt <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(enq_n);
            rd_ptr     <= rd_ptr + AW'(deq);
            count      <= count + (AW+1)'(enq_n) - (AW+1)'(deq);
            ovf        <= ovf | (m_valid & ~enq_m) | (s_valid & ~enq_s);
            commit_cnt <= commit_cnt + 32'(enq_n);
        end
    end
    // storage is not reset, so the head is masked while empty
    assign trace_valid = count != '0;
    assign {trace_pc, trace_wen, trace_wnum, trace_wdata} = trace_valid ? head : '0;
    assign stall_req   = free < (AW+1)'(2);
`else
    logic unused_ok;
    assign unused_ok   = ^{trace_ready, m_pc, s_pc, DEPTH[0]};
    assign trace_valid = 1'b0;
    assign trace_pc    = '0;
    assign trace_wen   = '0;
    assign trace_wnum  = '0;
    assign trace_wdata = '0;
    assign stall_req   = 1'b0;
    assign ovf         = 1'b0;
    always_ff @(posedge clk) begin
        if (rst) commit_cnt <= '0;
        else commit_cnt <= commit_cnt + 32'(m_valid) + 32'(s_valid);
    end
`endif
endmodule

// File: tb/tb_wb_trace_serializer.sv
// tb_wb_trace_serializer: directed self-checking bench for wb_trace_serializer
module tb_wb_trace_serializer;
`ifdef WB_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    logic        clk = 1'b0, rst;
    logic        m_valid, m_wen, s_valid, s_wen, trace_ready;
    logic [4:0]  m_waddr, s_waddr;
    logic [31:0] m_wdata, m_pc, s_wdata, s_pc;
    logic        rf_we1, rf_we2, trace_valid, stall_req, ovf;
    logic [4:0]  rf_waddr1, rf_waddr2, trace_wnum;
    logic [31:0] rf_wdata1, rf_wdata2, trace_pc, trace_wdata, commit_cnt;
    logic [3:0]  trace_wen;
    int vecs = 0, errs = 0;

    wb_trace_serializer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_pc(m_pc),
        .s_valid(s_valid), .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_pc(s_pc),
        .rf_we1(rf_we1), .rf_waddr1(rf_waddr1), .rf_wdata1(rf_wdata1),
        .rf_we2(rf_we2), .rf_waddr2(rf_waddr2), .rf_wdata2(rf_wdata2),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
        .stall_req(stall_req), .ovf(ovf), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        m_valid = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_pc = 0;
        s_valid = 0; s_wen = 0; s_waddr = 0; s_wdata = 0; s_pc = 0;
    endtask

    task automatic set_m(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        m_valid = 1; m_wen = 1; m_waddr = a; m_wdata = d; m_pc = pc;
    endtask

    task automatic set_s(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        s_valid = 1; s_wen = 1; s_waddr = a; s_wdata = d; s_pc = pc;
    endtask

    task automatic test_reset;
        idle(); trace_ready = 0; rst = 1;
        step();
        rst = 0;
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", trace_valid); end
        vecs++; if (commit_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", commit_cnt); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL reset_stall got %0b want 0", stall_req); end
        vecs++; if (trace_pc !== 32'd0) begin errs++; $display("FAIL reset_pc got %h want 0", trace_pc); end
    endtask

    task automatic test_single;
        set_m(32'hBFC00000, 5, 32'h1234); trace_ready = 1;
        #1;
        vecs++; if (rf_we1 !== 1'b1) begin errs++; $display("FAIL single_we1 got %0b want 1", rf_we1); end
        vecs++; if (rf_waddr1 !== 5'd5 || rf_wdata1 !== 32'h1234) begin errs++; $display("FAIL single_pass got %0d/%h want 5/1234", rf_waddr1, rf_wdata1); end
        vecs++; if (rf_we2 !== 1'b0) begin errs++; $display("FAIL single_we2 got %0b want 0", rf_we2); end
        step(); idle();
        vecs++; if (trace_valid !== TR) begin errs++; $display("FAIL single_valid got %0b want %0b", trace_valid, TR); end
        vecs++; if (trace_pc !== (TR ? 32'hBFC00000 : 32'h0)) begin errs++; $display("FAIL single_pc got %h", trace_pc); end
        vecs++; if (trace_wen !== (TR ? 4'hF : 4'h0)) begin errs++; $display("FAIL single_wen got %h", trace_wen); end
        vecs++; if (trace_wnum !== (TR ? 5'd5 : 5'd0) || trace_wdata !== (TR ? 32'h1234 : 32'h0)) begin errs++; $display("FAIL single_data got %0d/%h", trace_wnum, trace_wdata); end
        vecs++; if (commit_cnt !== 32'd1) begin errs++; $display("FAIL single_cnt got %0d want 1", commit_cnt); end
        step();
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL single_deq got %0b want 0", trace_valid); end
        step();
        vecs++; if (trace_valid !== 1'b0 || commit_cnt !== 32'd1) begin errs++; $display("FAIL empty_ready got %0b/%0d want 0/1", trace_valid, commit_cnt); end
    endtask

    task automatic test_waw;
        trace_ready = 0;
        set_m(32'h0, 3, 32'h1); set_s(32'h0, 4, 32'h2);
        #1;
        vecs++; if (rf_we1 !== 1'b1 || rf_we2 !== 1'b1) begin errs++; $display("FAIL diff_dest got %0b%0b want 11", rf_we1, rf_we2); end
        set_m(32'h0, 8, 32'h1); set_s(32'h0, 8, 32'h2); s_wen = 0;
        #1;
        vecs++; if (rf_we1 !== 1'b1 || rf_we2 !== 1'b0) begin errs++; $display("FAIL slave_nowen got %0b%0b want 10", rf_we1, rf_we2); end
        set_m(32'h100, 8, 32'hA); set_s(32'h104, 8, 32'hB);
        #1;
        vecs++; if (rf_we1 !== 1'b0 || rf_we2 !== 1'b1) begin errs++; $display("FAIL waw got %0b%0b want 01", rf_we1, rf_we2); end
        vecs++; if (rf_waddr2 !== 5'd8 || rf_wdata2 !== 32'hB) begin errs++; $display("FAIL waw_pass got %0d/%h want 8/b", rf_waddr2, rf_wdata2); end
        step(); idle();
        vecs++; if (commit_cnt !== 32'd3) begin errs++; $display("FAIL waw_cnt got %0d want 3", commit_cnt); end
        vecs++; if (trace_pc !== (TR ? 32'h100 : 32'h0) || trace_wdata !== (TR ? 32'hA : 32'h0)) begin errs++; $display("FAIL waw_first got %h/%h", trace_pc, trace_wdata); end
        trace_ready = 1;
        step();
        vecs++; if (trace_pc !== (TR ? 32'h104 : 32'h0) || trace_wnum !== (TR ? 5'd8 : 5'd0)) begin errs++; $display("FAIL waw_second got %h/%0d", trace_pc, trace_wnum); end
        step();
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL waw_drain got %0b want 0", trace_valid); end
    endtask

    task automatic test_zero_reg;
        trace_ready = 0;
        set_m(32'h200, 0, 32'h55);
        #1;
        vecs++; if (rf_we1 !== 1'b0) begin errs++; $display("FAIL zero_we1 got %0b want 0", rf_we1); end
        step(); idle();
        vecs++; if (trace_valid !== TR || trace_pc !== (TR ? 32'h200 : 32'h0)) begin errs++; $display("FAIL zero_traced got %0b/%h", trace_valid, trace_pc); end
        vecs++; if (trace_wen !== 4'h0 || trace_wnum !== 5'd0) begin errs++; $display("FAIL zero_wen got %h/%0d want 0/0", trace_wen, trace_wnum); end
        vecs++; if (commit_cnt !== 32'd4) begin errs++; $display("FAIL zero_cnt got %0d want 4", commit_cnt); end
        trace_ready = 1;
        step();
        trace_ready = 0;
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc [8] = '{32'h300, 32'h310, 32'h314, 32'h318, 32'h31C, 32'h320, 32'h324, 32'h328};
        trace_ready = 0;
        set_m(32'h300, 1, 32'h1);
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            set_m(32'h310 + 8 * k, 2, k); set_s(32'h314 + 8 * k, 3, k);
            step(); idle();
            if (k == 1) begin
                vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL stall_at5 got %0b want 0", stall_req); end
            end
        end
        vecs++; if (stall_req !== TR || ovf !== 1'b0) begin errs++; $display("FAIL stall_at7 got %0b/%0b want %0b/0", stall_req, ovf, TR); end
        vecs++; if (commit_cnt !== 32'd11) begin errs++; $display("FAIL bp_cnt got %0d want 11", commit_cnt); end
        set_m(32'h328, 2, 32'h7); set_s(32'h32C, 3, 32'h7);
        step(); idle();
        vecs++; if (ovf !== TR || stall_req !== TR) begin errs++; $display("FAIL ovf_set got %0b/%0b want %0b", ovf, stall_req, TR); end
        vecs++; if (commit_cnt !== (TR ? 32'd12 : 32'd13)) begin errs++; $display("FAIL ovf_cnt got %0d", commit_cnt); end
        set_m(32'h330, 2, 32'h8); set_s(32'h334, 3, 32'h8);
        step(); idle();
        vecs++; if (ovf !== TR || commit_cnt !== (TR ? 32'd12 : 32'd15)) begin errs++; $display("FAIL full_drop got %0b/%0d", ovf, commit_cnt); end
        trace_ready = 1;
        for (int i = 0; i < 8; i++) begin
            vecs++; if (trace_valid !== TR || trace_pc !== (TR ? exp_pc[i] : 32'h0)) begin errs++; $display("FAIL drain%0d got %0b/%h want %h", i, trace_valid, trace_pc, exp_pc[i]); end
            step();
        end
        vecs++; if (trace_valid !== 1'b0 || stall_req !== 1'b0 || ovf !== TR) begin errs++; $display("FAIL drained got %0b/%0b/%0b", trace_valid, stall_req, ovf); end
    endtask

    task automatic test_enq_deq;
        trace_ready = 1;
        set_m(32'h400, 9, 32'h9);
        step(); idle();
        vecs++; if (trace_pc !== (TR ? 32'h400 : 32'h0)) begin errs++; $display("FAIL wrap_pc got %h", trace_pc); end
        set_s(32'h404, 10, 32'hA);
        #1;
        vecs++; if (rf_we1 !== 1'b0 || rf_we2 !== 1'b1) begin errs++; $display("FAIL slave_only_we got %0b%0b want 01", rf_we1, rf_we2); end
        step(); idle();
        vecs++; if (trace_valid !== TR || trace_pc !== (TR ? 32'h404 : 32'h0)) begin errs++; $display("FAIL slave_only got %0b/%h", trace_valid, trace_pc); end
        vecs++; if (commit_cnt !== (TR ? 32'd14 : 32'd17)) begin errs++; $display("FAIL enqdeq_cnt got %0d", commit_cnt); end
        step();
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL enqdeq_drain got %0b want 0", trace_valid); end
    endtask

    task automatic test_reset_mid;
        trace_ready = 0;
        set_m(32'h500, 1, 1); set_s(32'h504, 2, 2); step();
        set_m(32'h508, 1, 1); set_s(32'h50C, 2, 2); step();
        idle(); set_m(32'h510, 1, 1); step(); idle();
        vecs++; if (trace_pc !== (TR ? 32'h500 : 32'h0) || ovf !== TR) begin errs++; $display("FAIL pre_rst got %h/%0b", trace_pc, ovf); end
        rst = 1; trace_ready = 1; set_m(32'h600, 7, 32'h77);
        #1;
        vecs++; if (rf_we1 !== 1'b1) begin errs++; $display("FAIL rst_we1 got %0b want 1", rf_we1); end
        step();
        rst = 0; idle(); trace_ready = 0;
        vecs++; if (trace_valid !== 1'b0 || commit_cnt !== 32'd0 || ovf !== 1'b0) begin errs++; $display("FAIL mid_rst got %0b/%0d/%0b want 0/0/0", trace_valid, commit_cnt, ovf); end
        vecs++; if (trace_pc !== 32'd0 || stall_req !== 1'b0) begin errs++; $display("FAIL mid_rst_out got %h/%0b want 0/0", trace_pc, stall_req); end
        step();
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL post_rst got %0b want 0", trace_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_waw();
        test_zero_reg();
        test_backpressure();
        test_enq_deq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
